// File: rtl/lmg_scheduler_if.sv
// Generator handshake between lmg_scheduler and the per-piece move generator.
// master = scheduler side, slave = generator side.
interface lmg_scheduler_if;
  logic        gen_req;
  logic [5:0]  gen_square;
  logic [3:0]  gen_piece;
  logic        gen_done;
  logic        mv_valid;
  logic [15:0] mv_data;
  logic        mv_ready;

  modport master (
    output gen_req, gen_square, gen_piece, mv_ready,
    input  gen_done, mv_valid, mv_data
  );

  modport slave (
    input  gen_req, gen_square, gen_piece, mv_ready,
    output gen_done, mv_valid, mv_data
  );
endinterface

// File: rtl/lmg_scheduler.sv
// LMG board scanner: feeds friendly squares to the move generator, stores moves.
// Optional LMG_ROW_SKIP_EN: rows without a friendly piece skip the column scan.
module lmg_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 13,
  parameter int RESULT_BASE = 16,
  parameter int MAX_MOVES   = 100,
  parameter int BOARD_BASE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  side,
  output logic [ADDR_WIDTH-1:0] brd_addr,
  input  logic [DATA_WIDTH-1:0] brd_rddata,
  lmg_scheduler_if.master       gen,
  output logic                  res_we,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0] res_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [6:0]            move_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, SCAN, REQ, DONE
  } state_t;

  state_t      state, state_nxt, row_end;
  logic        start_q, side_q;
  logic [2:0]  row, col;
  logic [31:0] row_buf;
  logic [3:0]  piece;
  logic        friendly, launch, accept;
  logic        adv, last_col, skip_row;

`ifdef LMG_ROW_SKIP_EN
  function automatic logic any_friendly(input logic [31:0] w,
                                        input logic s);
    any_friendly = 1'b0;
    for (int c = 0; c < 8; c++)
      if (w[4*c +: 4] != 4'h0 && w[4*c+3] == s)
        any_friendly = 1'b1;
  endfunction

  assign skip_row = (state == WAIT) &&
                    !any_friendly(brd_rddata[31:0], side_q);
`else
  assign skip_row = 1'b0;
`endif

  assign piece    = row_buf[{col, 2'b00} +: 4];
  assign friendly = (piece != 4'h0) && (piece[3] == side_q);
  assign launch   = start & ~start_q;
  assign accept   = gen.mv_valid & gen.mv_ready;
  assign last_col = (col == 3'd7);
  assign row_end  = (row == 3'd7) ? DONE : FETCH;
  assign adv      = (state == SCAN && !friendly) ||
                    (state == REQ && gen.gen_done);

  assign brd_addr = ADDR_WIDTH'(BOARD_BASE) + ADDR_WIDTH'(row);

  assign gen.gen_req    = (state == REQ);
  assign gen.mv_ready   = (state == REQ);
  assign gen.gen_square = {row, col};
  assign gen.gen_piece  = piece;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (launch) state_nxt = FETCH;
        FETCH:      state_nxt = WAIT;
        WAIT:       state_nxt = skip_row ? row_end : SCAN;
        SCAN: begin
          if (friendly)      state_nxt = REQ;
          else if (last_col) state_nxt = row_end;
        end
        REQ: begin
          if (gen.gen_done)
            state_nxt = last_col ? row_end : SCAN;
        end
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // start_q tracks start through reset so a level held across reset never launches
  always_ff @(posedge clk) begin
    start_q <= start;
    if (!reset) begin
      side_q     <= 1'b0;
      row        <= '0;
      col        <= '0;
      row_buf    <= '0;
      move_count <= '0;
      overflow   <= 1'b0;
      res_we     <= 1'b0;
      res_addr   <= ADDR_WIDTH'(RESULT_BASE);
      res_wdata  <= '0;
    end else begin
      res_we <= 1'b0;
      if (abort) begin
        move_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if ((state == IDLE || state == DONE) && launch) begin
          side_q     <= side;
          row        <= '0;
          col        <= '0;
          move_count <= '0;
          overflow   <= 1'b0;
        end
        if (state == WAIT) begin
          row_buf <= brd_rddata[31:0];
          col     <= '0;
          if (skip_row && row != 3'd7) row <= row + 3'd1;
        end
        if (adv) begin
          if (last_col) begin
            col <= '0;
            if (row != 3'd7) row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        if (accept) begin
          if (move_count < 7'(MAX_MOVES)) begin
            res_we     <= 1'b1;
            res_addr   <= ADDR_WIDTH'(RESULT_BASE) +
                          ADDR_WIDTH'(move_count);
            res_wdata  <= {{(DATA_WIDTH-16){1'b0}}, gen.mv_data};
            move_count <= move_count + 7'd1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lmg_scheduler.sv
// Testbench for lmg_scheduler: table-driven board scans with a generator
// stub, a write scoreboard, plus reset and abort sequences.
module tb_lmg_scheduler;
  localparam int AW = 13;
  localparam int DW = 32;
`ifdef LMG_ROW_SKIP_EN
  localparam int EMPTY_CYC = 16;
`else
  localparam int EMPTY_CYC = 80;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort, side;
  logic [AW-1:0] brd_addr, res_addr;
  logic [DW-1:0] brd_rddata, res_wdata;
  logic          res_we, busy, done, overflow;
  logic [6:0]    move_count;

  lmg_scheduler_if gen();

  lmg_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .side       (side),
    .brd_addr   (brd_addr),
    .brd_rddata (brd_rddata),
    .gen        (gen),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_wdata  (res_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic [7:0][31:0] b;
    logic             s;
    int               n;
    int               reqs;
    int               cnt;
    bit               ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0][31:0] board;
  logic [AW-1:0]    addr_q;
  int  n_moves;
  int  hold_sq = -1;
  int  stub_cnt, req_cnt, wr_cnt, exp_cnt;
  bit  exp_ovf, req_seen;
  int  exp_sq[$];
  wr_t sb[$];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0][31:0] b, input logic s);
    logic [31:0] w;
    logic [3:0]  nib;
    exp_sq.delete();
    for (int r = 0; r < 8; r++) begin
      w = b[r];
      for (int c = 0; c < 8; c++) begin
        nib = w[c*4 +: 4];
        if (nib != 4'h0 && nib[3] == s) exp_sq.push_back(r*8 + c);
      end
    end
  endtask

  // Board RAM (1-cycle latency), generator stub, and result monitor.
  always @(negedge clk) begin : model
    int          idx, sq;
    logic [31:0] w;
    wr_t         e;
    idx = int'(addr_q) - 2;
    brd_rddata = (idx >= 0 && idx < 8) ? board[idx] : '0;
    addr_q = brd_addr;

    if (res_we) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h",
                 res_addr, res_wdata);
      end else begin
        e = sb.pop_front();
        chk("res_addr", res_addr, e.a);
        chk("res_wdata", res_wdata, e.d);
      end
    end

    gen.mv_valid = 1'b0;
    gen.gen_done = 1'b0;
    if (!gen.gen_req) begin
      stub_cnt = 0;
      req_seen = 1'b0;
    end else begin
      sq = int'(gen.gen_square);
      if (!req_seen) begin
        req_seen = 1'b1;
        if (req_cnt < exp_sq.size()) begin
          chk("gen_square", sq, exp_sq[req_cnt]);
        end else begin
          checks++;
          errors++;
          $display("FAIL extra_gen_req: square %0d", sq);
        end
        w = board[sq / 8];
        chk("gen_piece", gen.gen_piece, w[(sq % 8)*4 +: 4]);
        req_cnt++;
      end
      if (sq != hold_sq) begin
        if (stub_cnt < n_moves) begin
          gen.mv_valid = 1'b1;
          gen.mv_data  = {2'b00, gen.gen_square, 8'(stub_cnt)};
          if (exp_cnt < 100) begin
            sb.push_back({AW'(16 + exp_cnt), {16'h0, gen.mv_data}});
            exp_cnt++;
          end else begin
            exp_ovf = 1'b1;
          end
          stub_cnt++;
          gen.gen_done = (stub_cnt == n_moves);
        end else begin
          gen.gen_done = 1'b1;
        end
      end
    end
  end

  task automatic setup(input logic [7:0][31:0] b, input logic s,
                       input int n);
    @(negedge clk);
    start   = 1'b0;
    board   = b;
    side    = s;
    n_moves = n;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    req_cnt = 0;
    wr_cnt  = 0;
    sb.delete();
    build_exp(b, s);
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic run(input logic [7:0][31:0] b, input logic s,
                     input int n, output int cyc);
    setup(b, s, n);
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (!done && cyc < 3000);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d cycles limit 3000", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t             tv[6];
  logic [7:0][31:0] b1;
  int               cyc, k;

  initial begin
    gen.mv_valid = 1'b0;
    gen.gen_done = 1'b0;
    gen.mv_data  = '0;
    reset      = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    side       = 1'b0;
    board      = '0;
    n_moves    = 0;
    brd_rddata = '0;
    addr_q     = '0;

    b1    = '0;
    b1[0] = 32'h42365324;
    b1[1] = 32'h11111111;

    tv[0] = '{b: '0, s: 1'b0, n: 2, reqs: 0,  cnt: 0,   ovf: 1'b0};
    tv[1] = '{b: b1, s: 1'b0, n: 2, reqs: 16, cnt: 32,  ovf: 1'b0};
    tv[2] = '{b: b1, s: 1'b0, n: 7, reqs: 16, cnt: 100, ovf: 1'b1};
    tv[3] = '{b: b1, s: 1'b1, n: 2, reqs: 0,  cnt: 0,   ovf: 1'b0};
    tv[4] = '{b: '0, s: 1'b1, n: 3, reqs: 2,  cnt: 6,   ovf: 1'b0};
    tv[4].b[3] = 32'h00009A01;
    tv[5] = '{b: b1, s: 1'b0, n: 0, reqs: 16, cnt: 0,   ovf: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_move_count", move_count, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_gen_req", gen.gen_req, 0);
    chk("rst_mv_ready", gen.mv_ready, 0);
    chk("rst_brd_addr", brd_addr, 2);
    chk("rst_res_addr", res_addr, 16);

    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("held_start_busy", busy, 0);
    chk("held_start_done", done, 0);

    for (int i = 0; i < 6; i++) begin
      run(tv[i].b, tv[i].s, tv[i].n, cyc);
      if (i == 0) chk("empty_cycles", cyc, EMPTY_CYC);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_move_count", i), move_count, tv[i].cnt);
      chk($sformatf("v%0d_overflow", i), overflow, tv[i].ovf);
      chk($sformatf("v%0d_reqs", i), req_cnt, tv[i].reqs);
      chk($sformatf("v%0d_writes", i), wr_cnt, tv[i].cnt);
      chk($sformatf("v%0d_sb_left", i), sb.size(), 0);
    end

    // Abort while the generator is stalled on square 3.
    hold_sq = 3;
    setup(b1, 1'b0, 2);
    k = 0;
    while (!(gen.gen_req && gen.gen_square == 6'd3) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_sq3", gen.gen_req && gen.gen_square == 6'd3, 1);
    chk("abort_pre_count", move_count, 6);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_gen_req", gen.gen_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_move_count", move_count, 0);
    @(negedge clk);
    abort   = 1'b0;
    hold_sq = -1;
    chk("abort_writes", wr_cnt, 6);
    chk("abort_sb_left", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);

    run(b1, 1'b0, 2, cyc);
    chk("rerun_done", done, 1);
    chk("rerun_move_count", move_count, 32);
    chk("rerun_overflow", overflow, 0);
    chk("rerun_reqs", req_cnt, 16);
    chk("rerun_writes", wr_cnt, 32);
    chk("rerun_sb_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lmg_scheduler.md
# lmg_scheduler

Sequencer for the legal-move-generator (LMG) datapath behind the `control` Avalon-MM slave. On a start request it scans the 8-row board-state RAM square by square. For every square holding a piece of the side to move, it hands that square to the per-piece move generator and collects the returned moves into the result region of slave RAM, starting at word 16. It reports busy, done, move count and overflow back to the control register.

## Interface
- DATA_WIDTH, 32, board/result word width
- ADDR_WIDTH, 13, slave RAM word-address width
- RESULT_BASE, 16, first result word address
- MAX_MOVES, 100, result words available; moves beyond this are dropped
- BOARD_BASE, 2, word address of board row 0 (rows 0..7 at BOARD_BASE..BOARD_BASE+7)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low; low at an edge forces reset state
- start  in  1  level from control bit 0; rising edge (sampled) launches a scan
- abort  in  1  control bit 1; high forces return to IDLE
- side  in  1  side to move (0 white, 1 black), sampled at launch
- brd_addr  out  ADDR_WIDTH  board row read address
- brd_rddata  in  DATA_WIDTH  row word, valid one cycle after brd_addr
- gen_req  out  1  request to generator
- gen_square  out  6  square index row*8+col
- gen_piece  out  4  piece nibble
- gen_done  in  1  one-cycle pulse: generator finished current square
- mv_valid  in  1  move available
- mv_data  in  16  encoded move
- mv_ready  out  1  scheduler accepts move
- res_we  out  1  result RAM write strobe
- res_addr  out  ADDR_WIDTH  result write address
- res_wdata  out  DATA_WIDTH  {16'h0, mv_data}
- busy, done, overflow  out  1 each  status
- move_count  out  7  moves written, saturates at MAX_MOVES

## Operation
- Board encoding: nibble c of row word (bits 4c+3:4c) is column c. 0 = empty. Bit 3 = colour (1 black). Bits 2:0 = type 1..6.
- Friendly piece: nibble nonzero and bit3 == latched side.
- States: IDLE, FETCH, WAIT, SCAN, REQ, DONE.
- IDLE/DONE:
  - start rising edge → clear move_count/overflow/done, latch side, row=0 → FETCH.
  - start held high does not relaunch.
- FETCH: drive brd_addr = BOARD_BASE+row → WAIT.
- WAIT: capture brd_rddata into row buffer, col=0 → SCAN.
- SCAN (one column per cycle):
  - Friendly piece → REQ.
  - Otherwise advance col.
  - After col 7: row+1 → FETCH, or DONE after row 7.
- REQ:
  - gen_req=1, gen_square/gen_piece held stable.
  - On gen_done → SCAN at col+1, with the same row/next-row advance rule.
- mv_ready=1 in REQ only. Each accepted move (mv_valid&mv_ready):
  - If move_count<MAX_MOVES: write to RESULT_BASE+move_count, then increment.
  - Else drop the move and set overflow.
- A move accepted in the same cycle as gen_done is accepted.
- abort high in any state: next state IDLE, busy=0, done=0, move_count=0, gen_req=0. abort has priority over start.

## Timing
- Reset values:
  - all outputs 0.
  - brd_addr = BOARD_BASE.
  - res_addr = RESULT_BASE.
  - state IDLE.
- Board read latency is 1 cycle. FETCH→WAIT→SCAN is 2 cycles per row.
- busy=1 from the cycle after the start edge until DONE entered. done is a level that stays high until the next launch, abort or reset.
- Result write is registered: res_we/res_addr/res_wdata are asserted in the cycle after acceptance, for one cycle.
- Empty board, macro off: DONE is reached 80 cycles after the start edge (8 rows × 10).
- REQ adds 1 entry cycle plus the generator latency. The earliest exit is 1 cycle after gen_done.
- gen_done outside REQ is ignored.

## Configuration
- LMG_ROW_SKIP_EN defined:
  - In WAIT, a row with no friendly nibble skips SCAN and goes straight to FETCH of the next row, or DONE after row 7.
  - Empty board reaches DONE 16 cycles after the start edge.
- Undefined: every row takes 8 SCAN cycles. Functional results are identical either way.

## Test plan
- Reset: hold reset=0 two cycles with start=1 → all outputs 0, state IDLE. Release with start still high → no launch until start falls and rises.
- Empty board, side=0, start edge → no gen_req, done=1 and move_count=0 at cycle 80 (macro off) / 16 (macro on).
- Row 0 = 0x42365324, row 1 = 0x11111111, side=0, stub emits 2 moves per square → 16 gen_reqs with squares 0..15, 32 writes to addresses 16..47, move_count=32, overflow=0.
- Same board, stub emits 7 moves per square (112) → writes stop at address 115, move_count=100, overflow=1, done=1.
- Same board, side=1 → zero gen_reqs, done=1, move_count=0.
- abort pulse while in REQ on square 3 → IDLE next cycle, gen_req=0, busy=0, move_count=0. A new start edge then re-runs from square 0 with the full result.
